// File: rtl/sipo_rx.sv
// UART receive deserializer: oversampled serial line in, byte plus status flags out.
// Frame format (data length, parity, stop bits) is latched at the start-bit sample.
module sipo_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int CNT_W      = 4
) (
   input  logic       BaudOut,
   input  logic       Reset,
   input  logic       DataIn,
   input  logic       StopBits,
   input  logic       DataLength,
   input  logic [1:0] ParityType,
   output logic [7:0] DataOut,
   output logic       DoneFlag,
   output logic       ActiveFlag,
   output logic       ParityError,
   output logic       StopError,
   output logic       StartError
);

   localparam int SYNC_STAGES = 2;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE
   } rxState_t;

   rxState_t         stateReg, stateNext;
   logic [CNT_W-1:0] cntReg, cntNext;
   logic [2:0]       bitIdxReg, bitIdxNext;
   logic [7:0]       shiftReg, shiftNext;
   logic             pbitReg, pbitNext;
   logic             stopPendReg, stopPendNext;
   logic             cfgStopReg, cfgStopNext;
   logic             cfgLenReg, cfgLenNext;
   logic [1:0]       cfgParityReg, cfgParityNext;
   logic [7:0]       dataOutReg, dataOutNext;
   logic             parityErrReg, parityErrNext;
   logic             stopErrReg, stopErrNext;
   logic             doneReg, doneNext;
   logic             activeReg, activeNext;
   logic             startErrReg, startErrNext;

   logic             syncReg [SYNC_STAGES];
   logic             sin;
   logic [7:0]       dataMasked;
   logic             parityOn;
   logic             parityCalc;
   logic             sampleTick;
   logic             lastData;
   logic             lastStop;

   genvar gi;
   generate
      // Both synchronizer flops reset to the idle (high) line level.
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : gSync
         if (gi == 0) begin : gHead
            always_ff @(posedge BaudOut) begin
               if (Reset) syncReg[gi] <= 1'b1;
               else       syncReg[gi] <= DataIn;
            end
         end else begin : gTail
            always_ff @(posedge BaudOut) begin
               if (Reset) syncReg[gi] <= 1'b1;
               else       syncReg[gi] <= syncReg[gi-1];
            end
         end
      end

      for (gi = 0; gi < 8; gi++) begin : gMask
         if (gi == 7) begin : gTop
            assign dataMasked[gi] = shiftReg[gi] & cfgLenReg;
         end else begin : gLow
            assign dataMasked[gi] = shiftReg[gi];
         end
      end
   endgenerate

   assign sin        = syncReg[SYNC_STAGES-1];
   assign parityOn   = (cfgParityReg == 2'b01) || (cfgParityReg == 2'b10);
   assign parityCalc = (^dataMasked) ^ pbitReg;
   assign sampleTick = (cntReg == BIT_LAST);
   assign lastData   = (bitIdxReg == (cfgLenReg ? 3'd7 : 3'd6));
   // bitIdx counts stop samples too: done after index 0 (one stop) or index 1 (two stops).
   assign lastStop   = (bitIdxReg[0] == cfgStopReg);

   always_ff @(posedge BaudOut) begin
      if (Reset) begin
         stateReg     <= IDLE;
         cntReg       <= '0;
         bitIdxReg    <= '0;
         shiftReg     <= '0;
         pbitReg      <= 1'b0;
         stopPendReg  <= 1'b0;
         cfgStopReg   <= 1'b0;
         cfgLenReg    <= 1'b1;
         cfgParityReg <= 2'b00;
         dataOutReg   <= '0;
         parityErrReg <= 1'b0;
         stopErrReg   <= 1'b0;
         doneReg      <= 1'b0;
         activeReg    <= 1'b0;
         startErrReg  <= 1'b0;
      end else begin
         stateReg     <= stateNext;
         cntReg       <= cntNext;
         bitIdxReg    <= bitIdxNext;
         shiftReg     <= shiftNext;
         pbitReg      <= pbitNext;
         stopPendReg  <= stopPendNext;
         cfgStopReg   <= cfgStopNext;
         cfgLenReg    <= cfgLenNext;
         cfgParityReg <= cfgParityNext;
         dataOutReg   <= dataOutNext;
         parityErrReg <= parityErrNext;
         stopErrReg   <= stopErrNext;
         doneReg      <= doneNext;
         activeReg    <= activeNext;
         startErrReg  <= startErrNext;
      end
   end

   always_comb begin
      stateNext     = stateReg;
      cntNext       = cntReg;
      bitIdxNext    = bitIdxReg;
      shiftNext     = shiftReg;
      pbitNext      = pbitReg;
      stopPendNext  = stopPendReg;
      cfgStopNext   = cfgStopReg;
      cfgLenNext    = cfgLenReg;
      cfgParityNext = cfgParityReg;
      dataOutNext   = dataOutReg;
      parityErrNext = parityErrReg;
      stopErrNext   = stopErrReg;
      doneNext      = 1'b0;
      startErrNext  = 1'b0;
      activeNext    = (stateReg == START) || (stateReg == DATA) ||
                      (stateReg == PARITY) || (stateReg == STOP);

      case (stateReg)
         IDLE: begin
            if (!sin) begin
               stateNext = START;
               cntNext   = '0;
            end
         end

         START: begin
            if (cntReg == HALF_LAST) begin
               cntNext = '0;
               if (!sin) begin
                  stateNext     = DATA;
                  bitIdxNext    = '0;
                  shiftNext     = '0;
                  pbitNext      = 1'b0;
                  stopPendNext  = 1'b0;
                  cfgStopNext   = StopBits;
                  cfgLenNext    = DataLength;
                  cfgParityNext = ParityType;
               end else begin
                  stateNext    = IDLE;
                  startErrNext = 1'b1;
               end
            end else begin
               cntNext = cntReg + CNT_W'(1);
            end
         end

         DATA: begin
            if (sampleTick) begin
               cntNext              = '0;
               shiftNext[bitIdxReg] = sin;
               if (lastData) begin
                  bitIdxNext = '0;
                  stateNext  = parityOn ? PARITY : STOP;
               end else begin
                  bitIdxNext = bitIdxReg + 3'd1;
               end
            end else begin
               cntNext = cntReg + CNT_W'(1);
            end
         end

         PARITY: begin
            if (sampleTick) begin
               cntNext    = '0;
               pbitNext   = sin;
               bitIdxNext = '0;
               stateNext  = STOP;
            end else begin
               cntNext = cntReg + CNT_W'(1);
            end
         end

         STOP: begin
            if (sampleTick) begin
               cntNext = '0;
               if (!sin) stopPendNext = 1'b1;
               if (lastStop) begin
                  stateNext  = DONE;
                  bitIdxNext = '0;
               end else begin
                  bitIdxNext = bitIdxReg + 3'd1;
               end
            end else begin
               cntNext = cntReg + CNT_W'(1);
            end
         end

         DONE: begin
            dataOutNext = dataMasked;
            case (cfgParityReg)
               2'b01:   parityErrNext = ~parityCalc;
               2'b10:   parityErrNext = parityCalc;
               default: parityErrNext = 1'b0;
            endcase
            stopErrNext = stopPendReg;
            doneNext    = 1'b1;
            cntNext     = '0;
            stateNext   = IDLE;
         end

         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   assign DataOut     = dataOutReg;
   assign DoneFlag    = doneReg;
   assign ActiveFlag  = activeReg;
   assign ParityError = parityErrReg;
   assign StopError   = stopErrReg;
   assign StartError  = startErrReg;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: builds serial frames, queues expected results, checks them on DoneFlag.
module tb_sipo_rx;

   logic       clk = 1'b0;
   logic       Reset;
   logic       DataIn;
   logic       StopBits;
   logic       DataLength;
   logic [1:0] ParityType;
   logic [7:0] DataOut;
   logic       DoneFlag;
   logic       ActiveFlag;
   logic       ParityError;
   logic       StopError;
   logic       StartError;

   always #5 clk = ~clk;

   sipo_rx #(.OVERSAMPLE(16), .CNT_W(4)) dut (
      .BaudOut    (clk),
      .Reset      (Reset),
      .DataIn     (DataIn),
      .StopBits   (StopBits),
      .DataLength (DataLength),
      .ParityType (ParityType),
      .DataOut    (DataOut),
      .DoneFlag   (DoneFlag),
      .ActiveFlag (ActiveFlag),
      .ParityError(ParityError),
      .StopError  (StopError),
      .StartError (StartError)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       serr;
      int         doneEdge;
   } exp_t;

   exp_t sbq[$];

   function automatic logic [31:0] frame_bits(input logic [7:0] d, input logic len8,
                                              input logic [1:0] pt, input logic flip,
                                              input logic two, input logic stop2Val,
                                              output int n);
      logic [31:0] b;
      logic [7:0]  dm;
      int          idx;
      int          nd;
      b     = '1;
      nd    = len8 ? 8 : 7;
      dm    = len8 ? d : {1'b0, d[6:0]};
      b[0]  = 1'b0;
      for (int i = 0; i < nd; i++) b[1+i] = dm[i];
      idx = 1 + nd;
      if (pt == 2'b01 || pt == 2'b10) begin
         b[idx] = ((pt == 2'b01) ? ~(^dm) : (^dm)) ^ flip;
         idx++;
      end
      b[idx] = 1'b1;
      idx++;
      if (two) begin
         b[idx] = stop2Val;
         idx++;
      end
      n = idx;
      return b;
   endfunction

   task automatic sync_edge(output int e0);
      @(posedge clk);
      #1;
      e0 = cyc + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at_edge(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic drive_bits(input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         DataIn = bits[i];
         repeat (16) @(posedge clk);
         #1;
      end
      DataIn = 1'b1;
   endtask

   task automatic set_cfg(input logic stop2, input logic len8, input logic [1:0] pt);
      StopBits   = stop2;
      DataLength = len8;
      ParityType = pt;
   endtask

   task automatic push_exp(input logic [7:0] d, input logic pe, input logic se, input int e);
      exp_t ex;
      ex.data = d; ex.perr = pe; ex.serr = se; ex.doneEdge = e;
      sbq.push_back(ex);
   endtask

   task automatic wait_done(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (DoneFlag === 1'b1) begin
            got = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset;
      Reset  = 1'b1;
      DataIn = 1'b1;
      set_cfg(1'b0, 1'b1, 2'b00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++; if (DataOut !== 8'h00) begin mismatched++; $display("FAIL reset_dataout: got %h, required 00", DataOut); end
      compared++; if (DoneFlag !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b, required 0", DoneFlag); end
      compared++; if (ActiveFlag !== 1'b0) begin mismatched++; $display("FAIL reset_active: got %b, required 0", ActiveFlag); end
      compared++; if (ParityError !== 1'b0) begin mismatched++; $display("FAIL reset_perr: got %b, required 0", ParityError); end
      compared++; if (StopError !== 1'b0) begin mismatched++; $display("FAIL reset_serr: got %b, required 0", StopError); end
      compared++; if (StartError !== 1'b0) begin mismatched++; $display("FAIL reset_starterr: got %b, required 0", StartError); end
      @(posedge clk);
      #1;
      Reset = 1'b0;
      idle(8);
      compared++; if (ActiveFlag !== 1'b0) begin mismatched++; $display("FAIL idle_active: got %b, required 0", ActiveFlag); end
      $display("reset: outputs cleared, idle line keeps receiver quiet");
   endtask

   task automatic test_8n1;
      int          e0, n;
      bit          got;
      exp_t        ex;
      logic [31:0] bits;
      set_cfg(1'b0, 1'b1, 2'b00);
      sync_edge(e0);
      bits = frame_bits(8'h4A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, n);
      push_exp(8'h4A, 1'b0, 1'b0, e0 + 11 + 16 * (n - 1));
      fork
         drive_bits(bits, n);
         begin
            wait_done(400, got);
            ex = sbq.pop_front();
            compared++;
            if (!got) begin
               mismatched++; $display("FAIL 8n1_timeout: no DoneFlag, required data %h", ex.data);
            end else begin
               $display("frame 8n1: DataOut=%h PE=%b SE=%b at edge +%0d", DataOut, ParityError, StopError, cyc - e0);
               compared++; if (cyc !== ex.doneEdge) begin mismatched++; $display("FAIL 8n1_edge: got +%0d, required +%0d", cyc - e0, ex.doneEdge - e0); end
               compared++; if (DataOut !== ex.data) begin mismatched++; $display("FAIL 8n1_data: got %h, required %h", DataOut, ex.data); end
               compared++; if (ParityError !== ex.perr) begin mismatched++; $display("FAIL 8n1_perr: got %b, required %b", ParityError, ex.perr); end
               compared++; if (StopError !== ex.serr) begin mismatched++; $display("FAIL 8n1_serr: got %b, required %b", StopError, ex.serr); end
               @(negedge clk);
               compared++; if (DoneFlag !== 1'b0) begin mismatched++; $display("FAIL 8n1_pulse: DoneFlag got %b one cycle later, required 0", DoneFlag); end
            end
         end
         begin
            at_edge(e0 + 2);
            compared++; if (ActiveFlag !== 1'b0) begin mismatched++; $display("FAIL active_e2: got %b, required 0", ActiveFlag); end
            at_edge(e0 + 3);
            compared++; if (ActiveFlag !== 1'b1) begin mismatched++; $display("FAIL active_e3: got %b, required 1", ActiveFlag); end
            at_edge(e0 + 154);
            compared++; if (ActiveFlag !== 1'b1) begin mismatched++; $display("FAIL active_e154: got %b, required 1", ActiveFlag); end
            at_edge(e0 + 155);
            compared++; if (ActiveFlag !== 1'b0) begin mismatched++; $display("FAIL active_e155: got %b, required 0", ActiveFlag); end
         end
      join
      idle(20);
   endtask

   task automatic test_parity;
      // data, len8, parity type, flip parity bit, two stops, 2nd stop value, expected PE, SE
      logic [7:0] tData [3] = '{8'hA5, 8'hA5, 8'h42};
      logic       tLen  [3] = '{1'b1, 1'b1, 1'b0};
      logic [1:0] tPt   [3] = '{2'b01, 2'b01, 2'b10};
      logic       tFlip [3] = '{1'b0, 1'b1, 1'b0};
      logic       tTwo  [3] = '{1'b0, 1'b0, 1'b1};
      logic       tS2   [3] = '{1'b1, 1'b1, 1'b0};
      logic       tPe   [3] = '{1'b0, 1'b1, 1'b0};
      logic       tSe   [3] = '{1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 3; c++) begin
         int          e0, n;
         bit          got;
         exp_t        ex;
         logic [31:0] bits;
         set_cfg(tTwo[c], tLen[c], tPt[c]);
         sync_edge(e0);
         bits = frame_bits(tData[c], tLen[c], tPt[c], tFlip[c], tTwo[c], tS2[c], n);
         push_exp(tData[c], tPe[c], tSe[c], e0 + 11 + 16 * (n - 1));
         fork
            drive_bits(bits, n);
            begin
               wait_done(400, got);
               ex = sbq.pop_front();
               compared++;
               if (!got) begin
                  mismatched++; $display("FAIL parity%0d_timeout: no DoneFlag, required data %h", c, ex.data);
               end else begin
                  $display("frame parity%0d: DataOut=%h PE=%b SE=%b at edge +%0d", c, DataOut, ParityError, StopError, cyc - e0);
                  compared++; if (cyc !== ex.doneEdge) begin mismatched++; $display("FAIL parity%0d_edge: got +%0d, required +%0d", c, cyc - e0, ex.doneEdge - e0); end
                  compared++; if (DataOut !== ex.data) begin mismatched++; $display("FAIL parity%0d_data: got %h, required %h", c, DataOut, ex.data); end
                  compared++; if (ParityError !== ex.perr) begin mismatched++; $display("FAIL parity%0d_perr: got %b, required %b", c, ParityError, ex.perr); end
                  compared++; if (StopError !== ex.serr) begin mismatched++; $display("FAIL parity%0d_serr: got %b, required %b", c, StopError, ex.serr); end
               end
            end
         join
         idle(40);
      end
   endtask

   task automatic test_reset_midframe;
      int          e0, n;
      bit          got;
      exp_t        ex;
      logic [31:0] bits;
      set_cfg(1'b0, 1'b1, 2'b00);
      sync_edge(e0);
      bits = frame_bits(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, n);
      fork
         drive_bits(bits, 5);
         begin
            at_edge(e0 + 70);
            compared++; if (ActiveFlag !== 1'b1) begin mismatched++; $display("FAIL midreset_pre_active: got %b, required 1", ActiveFlag); end
            @(posedge clk);
            #1;
            Reset = 1'b1;
            @(posedge clk);
            #1;
            Reset = 1'b0;
            @(negedge clk);
            compared++; if (DataOut !== 8'h00) begin mismatched++; $display("FAIL midreset_data: got %h, required 00", DataOut); end
            compared++; if (ActiveFlag !== 1'b0) begin mismatched++; $display("FAIL midreset_active: got %b, required 0", ActiveFlag); end
            compared++; if (StopError !== 1'b0) begin mismatched++; $display("FAIL midreset_serr: got %b, required 0", StopError); end
            compared++; if (ParityError !== 1'b0) begin mismatched++; $display("FAIL midreset_perr: got %b, required 0", ParityError); end
         end
      join
      wait_done(60, got);
      compared++; if (got) begin mismatched++; $display("FAIL midreset_spurious_done: got a DoneFlag, required none"); end
      compared++; if (ActiveFlag !== 1'b0) begin mismatched++; $display("FAIL midreset_idle: ActiveFlag got %b, required 0", ActiveFlag); end
      $display("midframe reset: receiver back in idle");
      sync_edge(e0);
      push_exp(8'h3C, 1'b0, 1'b0, e0 + 11 + 16 * (n - 1));
      fork
         drive_bits(bits, n);
         begin
            wait_done(400, got);
            ex = sbq.pop_front();
            compared++;
            if (!got) begin
               mismatched++; $display("FAIL after_reset_timeout: no DoneFlag, required data %h", ex.data);
            end else begin
               $display("frame after_reset: DataOut=%h PE=%b SE=%b at edge +%0d", DataOut, ParityError, StopError, cyc - e0);
               compared++; if (DataOut !== ex.data) begin mismatched++; $display("FAIL after_reset_data: got %h, required %h", DataOut, ex.data); end
               compared++; if (StopError !== ex.serr) begin mismatched++; $display("FAIL after_reset_serr: got %b, required %b", StopError, ex.serr); end
               compared++; if (cyc !== ex.doneEdge) begin mismatched++; $display("FAIL after_reset_edge: got +%0d, required +%0d", cyc - e0, ex.doneEdge - e0); end
            end
         end
      join
      idle(20);
   endtask

   task automatic test_glitch;
      int          e0, n, pulses, pulseEdge, dones;
      bit          got;
      exp_t        ex;
      logic [31:0] bits;
      set_cfg(1'b0, 1'b1, 2'b00);
      sync_edge(e0);
      DataIn = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      DataIn    = 1'b1;
      pulses    = 0;
      pulseEdge = -1;
      dones     = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (StartError === 1'b1) begin
            pulses++;
            pulseEdge = cyc - e0;
         end
         if (DoneFlag === 1'b1) dones++;
         if (cyc == e0 + 12) begin
            compared++; if (ActiveFlag !== 1'b0) begin mismatched++; $display("FAIL glitch_active: got %b, required 0", ActiveFlag); end
         end
      end
      $display("glitch: StartError pulses=%0d at edge +%0d", pulses, pulseEdge);
      compared++; if (pulses !== 1) begin mismatched++; $display("FAIL glitch_pulses: got %0d, required 1", pulses); end
      compared++; if (pulseEdge !== 10) begin mismatched++; $display("FAIL glitch_edge: got +%0d, required +10", pulseEdge); end
      compared++; if (dones !== 0) begin mismatched++; $display("FAIL glitch_done: got %0d DoneFlag pulses, required 0", dones); end
      sync_edge(e0);
      bits = frame_bits(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, n);
      push_exp(8'h3C, 1'b0, 1'b0, e0 + 11 + 16 * (n - 1));
      fork
         drive_bits(bits, n);
         begin
            wait_done(400, got);
            ex = sbq.pop_front();
            compared++;
            if (!got) begin
               mismatched++; $display("FAIL post_glitch_timeout: no DoneFlag, required data %h", ex.data);
            end else begin
               $display("frame post_glitch: DataOut=%h PE=%b SE=%b at edge +%0d", DataOut, ParityError, StopError, cyc - e0);
               compared++; if (DataOut !== ex.data) begin mismatched++; $display("FAIL post_glitch_data: got %h, required %h", DataOut, ex.data); end
               compared++; if (cyc !== ex.doneEdge) begin mismatched++; $display("FAIL post_glitch_edge: got +%0d, required +%0d", cyc - e0, ex.doneEdge - e0); end
            end
         end
      join
      idle(20);
   endtask

   task automatic test_break;
      int   e0;
      bit   got;
      exp_t ex;
      set_cfg(1'b0, 1'b1, 2'b00);
      sync_edge(e0);
      push_exp(8'h00, 1'b0, 1'b1, e0 + 155);
      fork
         drive_bits(32'h0000_0000, 10);
         begin
            wait_done(400, got);
            ex = sbq.pop_front();
            compared++;
            if (!got) begin
               mismatched++; $display("FAIL break_timeout: no DoneFlag, required data %h", ex.data);
            end else begin
               $display("frame break: DataOut=%h PE=%b SE=%b at edge +%0d", DataOut, ParityError, StopError, cyc - e0);
               compared++; if (DataOut !== ex.data) begin mismatched++; $display("FAIL break_data: got %h, required %h", DataOut, ex.data); end
               compared++; if (StopError !== ex.serr) begin mismatched++; $display("FAIL break_serr: got %b, required %b", StopError, ex.serr); end
               compared++; if (cyc !== ex.doneEdge) begin mismatched++; $display("FAIL break_edge: got +%0d, required +%0d", cyc - e0, ex.doneEdge - e0); end
            end
         end
      join
      idle(40);
   endtask

   task automatic test_back_to_back;
      int          e0, n1, n2, prevEdge;
      bit          got;
      exp_t        ex;
      logic [31:0] f1, f2, bits;
      set_cfg(1'b0, 1'b1, 2'b00);
      f1 = frame_bits(8'h55, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, n1);
      f2 = frame_bits(8'hAA, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, n2);
      bits = {f2[15:0], f1[15:0]} & 32'hFFFF_FFFF;
      bits = (f2 << n1) | (f1 & ((32'h1 << n1) - 32'h1));
      sync_edge(e0);
      push_exp(8'h55, 1'b0, 1'b0, e0 + 155);
      push_exp(8'hAA, 1'b0, 1'b0, e0 + 315);
      prevEdge = 0;
      fork
         drive_bits(bits, n1 + n2);
         begin
            for (int f = 0; f < 2; f++) begin
               wait_done(400, got);
               ex = sbq.pop_front();
               compared++;
               if (!got) begin
                  mismatched++; $display("FAIL b2b%0d_timeout: no DoneFlag, required data %h", f, ex.data);
               end else begin
                  $display("frame b2b%0d: DataOut=%h PE=%b SE=%b at edge +%0d", f, DataOut, ParityError, StopError, cyc - e0);
                  compared++; if (DataOut !== ex.data) begin mismatched++; $display("FAIL b2b%0d_data: got %h, required %h", f, DataOut, ex.data); end
                  compared++; if (ParityError !== ex.perr) begin mismatched++; $display("FAIL b2b%0d_perr: got %b, required %b", f, ParityError, ex.perr); end
                  compared++; if (StopError !== ex.serr) begin mismatched++; $display("FAIL b2b%0d_serr: got %b, required %b", f, StopError, ex.serr); end
                  compared++; if (cyc !== ex.doneEdge) begin mismatched++; $display("FAIL b2b%0d_edge: got +%0d, required +%0d", f, cyc - e0, ex.doneEdge - e0); end
                  if (f == 1) begin
                     compared++; if (cyc - prevEdge !== 160) begin mismatched++; $display("FAIL b2b_spacing: got %0d edges, required 160", cyc - prevEdge); end
                  end
                  prevEdge = cyc;
               end
            end
         end
         begin
            at_edge(e0 + 40);
            set_cfg(1'b1, 1'b0, 2'b01);
            at_edge(e0 + 150);
            set_cfg(1'b0, 1'b1, 2'b00);
            at_edge(e0 + 200);
            set_cfg(1'b1, 1'b0, 2'b10);
            at_edge(e0 + 300);
            set_cfg(1'b0, 1'b1, 2'b00);
         end
      join
      idle(20);
   endtask

   initial begin
      Reset  = 1'b1;
      DataIn = 1'b1;
      set_cfg(1'b0, 1'b1, 2'b00);
      test_reset;
      test_8n1;
      test_parity;
      test_reset_midframe;
      test_glitch;
      test_break;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
